// File: rtl/spi_disp_pkg.sv
// Shared constants and types for the SPI display command controller.
package spi_disp_pkg;

  // Command opcodes accepted in the idle state
  localparam logic [7:0] OP_SET_DIGITS  = 8'h01;
  localparam logic [7:0] OP_SET_COLON   = 8'h02;
  localparam logic [7:0] OP_READ_DIGITS = 8'h03;
  localparam logic [7:0] OP_INCREMENT   = 8'h04;
  localparam logic [7:0] OP_SET_LED     = 8'h05;
  localparam logic [7:0] OP_STATUS      = 8'h06;

  // Default reply bytes
  localparam logic [7:0] ACK_DEFAULT = 8'h55;
  localparam logic [7:0] NAK_DEFAULT = 8'hEE;

  // Colon / decimal point encoding driven to the display
  localparam logic [1:0] COLON_ON   = 2'b00;
  localparam logic [1:0] COLON_DP   = 2'b01;
  localparam logic [1:0] COLON_NONE = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StDigHi,
    StDigLo,
    StColonArg,
    StLedArg,
    StReadLo
  } state_e;

  // True when both nibbles of a byte are valid BCD digits
  function automatic logic is_bcd_byte(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd4_inc.sv
// Combinational 4-digit BCD incrementer; 9999 wraps to 0000.
module bcd4_inc (
  input  logic [15:0] value,
  output logic [15:0] result
);

  logic [4:0] carry_chain;

  // Ripple a +1 through the digits, each 9 rolling to 0 and passing the carry on
  always_comb begin
    carry_chain    = 5'b0;
    carry_chain[0] = 1'b1;
    result         = value;
    for (int i = 0; i < 4; i++) begin
      if (carry_chain[i]) begin
        if (value[4*i +: 4] >= 4'd9) begin
          result[4*i +: 4] = 4'd0;
          carry_chain[i+1] = 1'b1;
        end else begin
          result[4*i +: 4] = value[4*i +: 4] + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_disp_ctrl.sv
// Command parser between the SPI slave byte interface and the 4-digit display.
// Owns the digit, colon, LED and error registers and loads SPI reply bytes.
module spi_disp_ctrl
  import spi_disp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1600000,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] colon,
  output logic       led,
  output logic       err
);

  // Counter holds 0..TIMEOUT_CYCLES-1; expiry fires on the cycle it would pass the last value
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] TmoLast =
      (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);
  localparam bit TmoEnable = (TIMEOUT_CYCLES != 0);

  state_e          state_q;
  logic [15:0]     digits_q;
  logic [15:0]     digits_inc;
  logic [7:0]      shadow_q;
  logic [1:0]      colon_q;
  logic            led_q;
  logic            cmd_err_q;
  logic            timeout_err_q;
  logic            tx_valid_q;
  logic [7:0]      tx_data_q;
  logic [CntW-1:0] tmo_q;

  logic            in_idle;
  logic            rx_take;

  assign in_idle = (state_q == StIdle);
  // Bytes are only meaningful while chip-select is held
  assign rx_take = rx_valid & cs_active;

  bcd4_inc u_bcd4_inc (
    .value  (digits_q),
    .result (digits_inc)
  );

  // Frame FSM with registered display state and reply outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      digits_q      <= '0;
      shadow_q      <= '0;
      colon_q       <= COLON_NONE;
      led_q         <= 1'b0;
      cmd_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      tmo_q         <= '0;
    end else begin
      tx_valid_q <= 1'b0;
      if (!in_idle && !cs_active) begin
        // Abort beats any byte arriving in the same cycle; nothing commits
        state_q  <= StIdle;
        shadow_q <= '0;
        tmo_q    <= '0;
      end else if (rx_take) begin
        tmo_q      <= '0;
        tx_valid_q <= 1'b1;
        tx_data_q  <= ACK_BYTE;
        unique case (state_q)
          StIdle: begin
            case (rx_data)
              OP_SET_DIGITS: state_q <= StDigHi;
              OP_SET_COLON:  state_q <= StColonArg;
              OP_SET_LED:    state_q <= StLedArg;
              OP_READ_DIGITS: begin
                state_q   <= StReadLo;
                tx_data_q <= digits_q[15:8];
              end
              OP_INCREMENT:  digits_q <= digits_inc;
              OP_STATUS: begin
                tx_data_q     <= {6'b0, timeout_err_q, cmd_err_q};
                cmd_err_q     <= 1'b0;
                timeout_err_q <= 1'b0;
              end
              default: begin
                cmd_err_q <= 1'b1;
                tx_data_q <= NAK_BYTE;
              end
            endcase
          end
          StDigHi: begin
            shadow_q <= rx_data;
            state_q  <= StDigLo;
          end
          StDigLo: begin
            // All four digits commit together or not at all
            if (is_bcd_byte(shadow_q) && is_bcd_byte(rx_data)) begin
              digits_q <= {shadow_q, rx_data};
            end else begin
              cmd_err_q <= 1'b1;
              tx_data_q <= NAK_BYTE;
            end
            state_q <= StIdle;
          end
          StColonArg: begin
            colon_q <= rx_data[1:0];
            state_q <= StIdle;
          end
          StLedArg: begin
            led_q   <= rx_data[0];
            state_q <= StIdle;
          end
          StReadLo: begin
            tx_data_q <= digits_q[7:0];
            state_q   <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end else if (!in_idle) begin
        if (TmoEnable && (tmo_q == TmoLast)) begin
          state_q       <= StIdle;
          shadow_q      <= '0;
          timeout_err_q <= 1'b1;
          tmo_q         <= '0;
        end else begin
          tmo_q <= tmo_q + CntW'(1);
        end
      end
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign digit0   = digits_q[3:0];
  assign digit1   = digits_q[7:4];
  assign digit2   = digits_q[11:8];
  assign digit3   = digits_q[15:12];
  assign colon    = colon_q;
  assign led      = led_q;
  assign err      = cmd_err_q | timeout_err_q;

endmodule

// File: tb/tb_spi_disp_ctrl.sv
// Self-checking bench for spi_disp_ctrl: fixed vector table, corner-case
// sequences and randomized traffic against a frame-level reference model.
module tb_spi_disp_ctrl;

  localparam int unsigned T   = 100;
  localparam logic [7:0]  ACK = 8'h55;
  localparam logic [7:0]  NAK = 8'hEE;

  logic       clk;
  logic       reset;
  logic       cs_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [1:0] colon;
  logic       led;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  spi_disp_ctrl #(
    .TIMEOUT_CYCLES (T),
    .ACK_BYTE       (ACK),
    .NAK_BYTE       (NAK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs_active (cs_active),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .colon     (colon),
    .led       (led),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  rx;
    logic [7:0]  tx;
    logic [15:0] digits;
    logic [1:0]  colon;
    logic        led;
    logic        err;
  } vec_t;

  vec_t vecs[28];

  // Reference model: displayed value kept as a decimal integer
  int         m_val;
  logic [1:0] m_colon;
  logic       m_led, m_cerr, m_terr;
  int         m_op;     // -1 when no frame is open, else the opcode awaiting payload
  int         m_nargs;
  logic [7:0] m_hold;
  int         m_since;  // cycles since last byte

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_colon = 2'b11; m_led = 1'b0; m_cerr = 1'b0; m_terr = 1'b0;
    m_op = -1; m_nargs = 0; m_hold = 8'h00; m_since = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic [7:0] rep);
    logic [15:0] d;
    d = to_bcd(m_val);
    rep = ACK;
    m_since = 0;
    if (m_op < 0) begin
      case (b)
        8'h01, 8'h02, 8'h05: begin m_op = int'(b); m_nargs = 0; end
        8'h03: begin m_op = 3; rep = d[15:8]; end
        8'h04: m_val = (m_val + 1) % 10000;
        8'h06: begin rep = {6'b0, m_terr, m_cerr}; m_terr = 1'b0; m_cerr = 1'b0; end
        default: begin m_cerr = 1'b1; rep = NAK; end
      endcase
    end else begin
      case (m_op)
        1: begin
          if (m_nargs == 0) begin
            m_hold = b; m_nargs = 1;
          end else begin
            if (m_hold[7:4] <= 9 && m_hold[3:0] <= 9 && b[7:4] <= 9 && b[3:0] <= 9)
              m_val = int'(m_hold[7:4]) * 1000 + int'(m_hold[3:0]) * 100
                    + int'(b[7:4]) * 10 + int'(b[3:0]);
            else begin
              m_cerr = 1'b1; rep = NAK;
            end
            m_op = -1;
          end
        end
        2: begin m_colon = b[1:0]; m_op = -1; end
        5: begin m_led = b[0]; m_op = -1; end
        default: begin rep = d[7:0]; m_op = -1; end
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_digits"}, {digit3, digit2, digit1, digit0}, to_bcd(m_val));
    chk({tag, "_colon"}, colon, m_colon);
    chk({tag, "_led"}, led, m_led);
    chk({tag, "_err"}, err, m_cerr | m_terr);
  endtask

  // Called at a negedge with cs_active high; returns at the next negedge
  task automatic xfer(input string tag, input logic [7:0] b, input logic [7:0] exp);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    chk({tag, "_txv"}, tx_valid, 1'b1);
    chk({tag, "_txd"}, tx_data, exp);
  endtask

  initial begin
    logic [7:0] b, exp;
    int r, k;

    vecs[0]  = '{8'h01, ACK,   16'h0000, 2'b11, 1'b0, 1'b0};
    vecs[1]  = '{8'h12, ACK,   16'h0000, 2'b11, 1'b0, 1'b0};
    vecs[2]  = '{8'h34, ACK,   16'h1234, 2'b11, 1'b0, 1'b0};
    vecs[3]  = '{8'h01, ACK,   16'h1234, 2'b11, 1'b0, 1'b0};
    vecs[4]  = '{8'h99, ACK,   16'h1234, 2'b11, 1'b0, 1'b0};
    vecs[5]  = '{8'h99, ACK,   16'h9999, 2'b11, 1'b0, 1'b0};
    vecs[6]  = '{8'h04, ACK,   16'h0000, 2'b11, 1'b0, 1'b0};
    vecs[7]  = '{8'h04, ACK,   16'h0001, 2'b11, 1'b0, 1'b0};
    vecs[8]  = '{8'h01, ACK,   16'h0001, 2'b11, 1'b0, 1'b0};
    vecs[9]  = '{8'h1A, ACK,   16'h0001, 2'b11, 1'b0, 1'b0};
    vecs[10] = '{8'h00, NAK,   16'h0001, 2'b11, 1'b0, 1'b1};
    vecs[11] = '{8'h06, 8'h01, 16'h0001, 2'b11, 1'b0, 1'b0};
    vecs[12] = '{8'h03, 8'h00, 16'h0001, 2'b11, 1'b0, 1'b0};
    vecs[13] = '{8'h00, 8'h01, 16'h0001, 2'b11, 1'b0, 1'b0};
    vecs[14] = '{8'h77, NAK,   16'h0001, 2'b11, 1'b0, 1'b1};
    vecs[15] = '{8'h06, 8'h01, 16'h0001, 2'b11, 1'b0, 1'b0};
    vecs[16] = '{8'h05, ACK,   16'h0001, 2'b11, 1'b0, 1'b0};
    vecs[17] = '{8'h01, ACK,   16'h0001, 2'b11, 1'b1, 1'b0};
    vecs[18] = '{8'h02, ACK,   16'h0001, 2'b11, 1'b1, 1'b0};
    vecs[19] = '{8'h01, ACK,   16'h0001, 2'b01, 1'b1, 1'b0};
    vecs[20] = '{8'h01, ACK,   16'h0001, 2'b01, 1'b1, 1'b0};
    vecs[21] = '{8'h01, ACK,   16'h0001, 2'b01, 1'b1, 1'b0};
    vecs[22] = '{8'h99, ACK,   16'h0199, 2'b01, 1'b1, 1'b0};
    vecs[23] = '{8'h04, ACK,   16'h0200, 2'b01, 1'b1, 1'b0};
    vecs[24] = '{8'h03, 8'h02, 16'h0200, 2'b01, 1'b1, 1'b0};
    vecs[25] = '{8'hAB, 8'h00, 16'h0200, 2'b01, 1'b1, 1'b0};
    vecs[26] = '{8'h02, ACK,   16'h0200, 2'b01, 1'b1, 1'b0};
    vecs[27] = '{8'h03, ACK,   16'h0200, 2'b11, 1'b1, 1'b0};

    reset = 1'b1; cs_active = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    chk("rst_colon", colon, 2'b11);
    chk("rst_led", led, 1'b0);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_err", err, 1'b0);

    // Fixed vector table, one byte per entry
    for (int i = 0; i < 28; i++) begin
      rx_valid = 1'b1;
      rx_data  = vecs[i].rx;
      chk($sformatf("vec%0d_early_txv", i), tx_valid, (i == 0) ? 1'b0 : 1'b1);
      @(negedge clk);
      rx_valid = 1'b0;
      chk($sformatf("vec%0d_txv", i), tx_valid, 1'b1);
      chk($sformatf("vec%0d_txd", i), tx_data, vecs[i].tx);
      chk($sformatf("vec%0d_digits", i), {digit3, digit2, digit1, digit0}, vecs[i].digits);
      chk($sformatf("vec%0d_colon", i), colon, vecs[i].colon);
      chk($sformatf("vec%0d_led", i), led, vecs[i].led);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
    end
    @(negedge clk);
    chk("pulse_width_txv", tx_valid, 1'b0);

    // Abort mid-frame by dropping chip-select; digits keep the old value
    xfer("abort_op", 8'h01, ACK);
    xfer("abort_hi", 8'h56, ACK);
    cs_active = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_txv", tx_valid, 1'b0);
    cs_active = 1'b1;
    xfer("abort_rd_hi", 8'h03, 8'h02);
    xfer("abort_rd_lo", 8'h00, 8'h00);
    chk("abort_digits", {digit3, digit2, digit1, digit0}, 16'h0200);
    chk("abort_err", err, 1'b0);

    // Abort and a byte in the same cycle: the byte is dropped
    xfer("absame_op", 8'h01, ACK);
    cs_active = 1'b0; rx_valid = 1'b1; rx_data = 8'h12;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("absame_txv", tx_valid, 1'b0);
    cs_active = 1'b1;
    xfer("absame_rd_hi", 8'h03, 8'h02);
    xfer("absame_rd_lo", 8'h00, 8'h00);

    // Byte with chip-select low in idle is ignored
    cs_active = 1'b0; rx_valid = 1'b1; rx_data = 8'h04;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("cslow_txv", tx_valid, 1'b0);
    cs_active = 1'b1;
    @(negedge clk);
    chk("cslow_digits", {digit3, digit2, digit1, digit0}, 16'h0200);

    // Inter-byte timeout
    xfer("tmo_op", 8'h02, ACK);
    repeat (T - 10) @(negedge clk);
    chk("tmo_early_err", err, 1'b0);
    repeat (15) @(negedge clk);
    chk("tmo_err", err, 1'b1);
    chk("tmo_colon", colon, 2'b11);
    chk("tmo_txv", tx_valid, 1'b0);
    xfer("tmo_status", 8'h06, 8'h02);
    chk("tmo_clr_err", err, 1'b0);
    xfer("tmo_idle_nak", 8'h00, NAK);
    xfer("tmo_status2", 8'h06, 8'h01);

    // Reset while waiting for the low digit byte
    xfer("rstmid_bad", 8'h77, NAK);
    xfer("rstmid_op", 8'h01, ACK);
    xfer("rstmid_hi", 8'h98, ACK);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    chk("rstmid_colon", colon, 2'b11);
    chk("rstmid_led", led, 1'b0);
    chk("rstmid_txv", tx_valid, 1'b0);
    chk("rstmid_txd", tx_data, 8'h00);
    chk("rstmid_err", err, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    xfer("rstmid_rd_hi", 8'h03, 8'h00);
    xfer("rstmid_rd_lo", 8'h00, 8'h00);

    // Randomized traffic against the reference model
    model_reset();
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        if (m_op < 0) begin
          b = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'($urandom_range(0, 7));
        end else if (m_op == 1) begin
          b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                          : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end else begin
          b = 8'($urandom_range(0, 255));
        end
        model_byte(b, exp);
        xfer($sformatf("rnd%0d", it), b, exp);
      end else if (r < 85) begin
        k = $urandom_range(1, 30);
        if (m_op < 0 || m_since + k < int'(T) - 10) begin
          repeat (k) @(negedge clk);
          m_since += k;
          chk($sformatf("rnd%0d_gap_txv", it), tx_valid, 1'b0);
        end
      end else if (r < 93) begin
        cs_active = 1'b0;
        rx_valid  = ($urandom_range(0, 1) == 1);
        rx_data   = 8'($urandom_range(0, 255));
        @(negedge clk);
        rx_valid = 1'b0;
        chk($sformatf("rnd%0d_cs_txv", it), tx_valid, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        cs_active = 1'b1;
        m_op = -1;
        m_since = 0;
      end else if (r < 97) begin
        k = $urandom_range(T + 5, T + 20);
        repeat (k) @(negedge clk);
        if (m_op >= 0) begin
          m_op = -1;
          m_terr = 1'b1;
        end
        m_since = 0;
        chk($sformatf("rnd%0d_long_txv", it), tx_valid, 1'b0);
      end
      check_model($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
